// File: rtl/camera_init_sequencer_pkg.sv
// Shared types and OV7725 constants for the camera init sequencer.
package camera_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_FETCH,
    ST_LOAD,
    ST_REQ,
    ST_RST_WAIT,
    ST_ERROR,
    ST_DONE
  } cis_state_e;

  localparam logic [7:0] OV7725_SCCB_ID    = 8'h42;
  localparam logic [7:0] OV_REG_COM7       = 8'h12;
  localparam int         OV_COM7_RESET_BIT = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/camera_init_sequencer_if.sv
// ROM fetch port and SCCB write-request handshake between the sequencer and its neighbours.
interface camera_init_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_q;
  logic                  wr_req;
  logic [7:0]            wr_dev_id;
  logic [7:0]            wr_reg_addr;
  logic [7:0]            wr_data;
  logic                  wr_ack;
  logic                  wr_err;

  modport master (
    output rom_addr, wr_req, wr_dev_id, wr_reg_addr, wr_data,
    input  rom_q, wr_ack, wr_err
  );

  modport slave (
    input  rom_addr, wr_req, wr_dev_id, wr_reg_addr, wr_data,
    output rom_q, wr_ack, wr_err
  );
endinterface

// File: rtl/camera_init_sequencer_delay.sv
// camera_init_delay: loadable down-counter shared by the power-up and soft-reset waits.
module camera_init_delay #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/camera_init_sequencer.sv
// camera_init_sequencer: walks the OV7725 init ROM and issues one SCCB write per entry.
// Build option CAMERA_INIT_RETRY_EN enables bounded retries of NACKed writes.
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_PWR_WAIT | power-up delay before the first fetch
// ST_FETCH    | ROM samples the index
// ST_LOAD     | rom_q valid, latch write fields
// ST_REQ      | write request outstanding
// ST_RST_WAIT | settle delay after a COM7 soft reset
// ST_ERROR    | retries exhausted, holding
// ST_DONE     | whole table written, holding
module camera_init_sequencer
  import camera_init_pkg::*;
#(
  parameter int         ADDR_WIDTH        = 8,
  parameter int         TABLE_LEN         = 68,
  parameter logic [7:0] DEVICE_ID         = OV7725_SCCB_ID,
  parameter int         POWERUP_CYCLES    = 1_000_000,
  parameter int         RESET_WAIT_CYCLES = 500_000,
  parameter int         MAX_RETRY         = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  camera_init_sequencer_if.master sccb,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   err_index
);
  localparam int CNT_W = max_int($clog2(max_int(POWERUP_CYCLES, RESET_WAIT_CYCLES) + 1), 1);
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(max_int(POWERUP_CYCLES, 1) - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(max_int(RESET_WAIT_CYCLES, 1) - 1);
  localparam logic [IDX_W-1:0] TLEN_IDX = IDX_W'(TABLE_LEN);

  cis_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_inc;
  logic                  wr_req_q, wr_req_d;
  logic [7:0]            reg_q, reg_d, data_q, data_d;
  logic [ADDR_WIDTH-1:0] err_idx_q, err_idx_d;
  logic                  dly_load, dly_count, dly_zero;
  logic [CNT_W-1:0]      dly_val;
  logic                  advance, rst_write;

`ifdef CAMERA_INIT_RETRY_EN
  localparam int RETRY_W = max_int($clog2(MAX_RETRY + 1), 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_q, retry_d;

  always_ff @(posedge clk) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`endif

  camera_init_delay #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (dly_load),
    .load_val (dly_val),
    .count    (dly_count),
    .zero     (dly_zero)
  );

  assign idx_inc   = idx_q + 1'b1;
  assign rst_write = (reg_q == OV_REG_COM7) && data_q[OV_COM7_RESET_BIT];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_req_d  = wr_req_q;
    reg_d     = reg_q;
    data_d    = data_q;
    err_idx_d = err_idx_q;
    dly_load  = 1'b0;
    dly_val   = PWR_LOAD;
    dly_count = 1'b0;
    advance   = 1'b0;
`ifdef CAMERA_INIT_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          idx_d     = '0;
          err_idx_d = '0;
          dly_load  = 1'b1;
`ifdef CAMERA_INIT_RETRY_EN
          retry_d   = '0;
`endif
          if (POWERUP_CYCLES != 0) state_d = ST_PWR_WAIT;
          else if (TABLE_LEN == 0) state_d = ST_DONE;
          else                     state_d = ST_FETCH;
        end
      end
      ST_PWR_WAIT: begin
        if (dly_zero) state_d = (TABLE_LEN == 0) ? ST_DONE : ST_FETCH;
        else          dly_count = 1'b1;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        reg_d    = sccb.rom_q[15:8];
        data_d   = sccb.rom_q[7:0];
        wr_req_d = 1'b1;
        state_d  = ST_REQ;
      end
      ST_REQ: begin
        // A NACK leaves wr_req low for one cycle; re-raise it here with the same fields.
        if (!wr_req_q) begin
          wr_req_d = 1'b1;
        end else if (sccb.wr_err) begin
          wr_req_d = 1'b0;
`ifdef CAMERA_INIT_RETRY_EN
          if (retry_q == RETRY_MAX) begin
            state_d   = ST_ERROR;
            err_idx_d = idx_q[ADDR_WIDTH-1:0];
          end else begin
            retry_d = retry_q + 1'b1;
          end
`else
          state_d   = ST_ERROR;
          err_idx_d = idx_q[ADDR_WIDTH-1:0];
`endif
        end else if (sccb.wr_ack) begin
          wr_req_d = 1'b0;
`ifdef CAMERA_INIT_RETRY_EN
          retry_d  = '0;
`endif
          if (rst_write && (RESET_WAIT_CYCLES != 0)) begin
            state_d  = ST_RST_WAIT;
            dly_load = 1'b1;
            dly_val  = RST_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_RST_WAIT: begin
        if (dly_zero) advance   = 1'b1;
        else          dly_count = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      idx_d   = idx_inc;
      state_d = (idx_inc == TLEN_IDX) ? ST_DONE : ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_req_q  <= 1'b0;
      reg_q     <= '0;
      data_q    <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_req_q  <= wr_req_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign sccb.rom_addr    = idx_q[ADDR_WIDTH-1:0];
  assign sccb.wr_req      = wr_req_q;
  assign sccb.wr_dev_id   = DEVICE_ID;
  assign sccb.wr_reg_addr = reg_q;
  assign sccb.wr_data     = data_q;
  assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign err_index = err_idx_q;
endmodule

// File: doc/camera_init_sequencer.md
# camera_init_sequencer

Sequencer that walks the OV7725 RGB register init ROM from entry 0 to `TABLE_LEN-1` and issues one SCCB register write per entry through a write-request handshake to the SCCB master. It enforces a power-up delay before the first write and a settle delay after any software-reset write (reg 0x12, bit 7). It retries NACKed writes and reports done or error to the capture pipeline. It sits between the init ROM and the SCCB master, and gates the start of frame capture.

## Interface
- `ADDR_WIDTH`, 8: ROM address width. Must match the ROM.
- `TABLE_LEN`, 68: number of valid ROM entries. Range 0..2**ADDR_WIDTH.
- `DEVICE_ID`, 8'h42: SCCB write address placed on `wr_dev_id`.
- `POWERUP_CYCLES`, 1_000_000: clocks to wait after `start` before the first fetch. 0 means no wait.
- `RESET_WAIT_CYCLES`, 500_000: clocks to wait after an acked write to reg 0x12 with data bit 7 = 1.
- `MAX_RETRY`, 3: additional attempts per entry after a NACK.
- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse. Begins the sequence from entry 0.
- `rom_addr`, out, ADDR_WIDTH: ROM address. Driven directly from the index register.
- `rom_q`, in, 16: ROM data `{reg_addr, data}`. Registered ROM, 1-cycle read latency.
- `wr_req`, out, 1: write request to the SCCB master.
- `wr_dev_id`, out, 8: equals `DEVICE_ID`.
- `wr_reg_addr`, out, 8: `rom_q[15:8]`, latched.
- `wr_data`, out, 8: `rom_q[7:0]`, latched.
- `wr_ack`, in, 1: one-cycle pulse. Write completed and ACKed.
- `wr_err`, in, 1: one-cycle pulse. Write completed with NACK.
- `busy`, out, 1: high in every state except IDLE, DONE and ERROR.
- `done`, out, 1: level. All entries written.
- `error`, out, 1: level. Retries exhausted.
- `err_index`, out, ADDR_WIDTH: index of the failing entry.

## Operation
- States: IDLE, PWR_WAIT, FETCH, LOAD, REQ, RST_WAIT, ERROR, DONE.
- **IDLE.** On `start`: go to PWR_WAIT, clear index and retry counter. If `POWERUP_CYCLES==0`, go directly to FETCH.
- **PWR_WAIT.** Count `POWERUP_CYCLES`, then go to FETCH. If `TABLE_LEN==0`, go to DONE instead.
- **FETCH.** Index is stable, ROM samples it. Lasts one cycle, then LOAD.
- **LOAD.** `rom_q` is valid. At the end of this cycle, register `wr_reg_addr` and `wr_data`, set `wr_req`=1, go to REQ.
- **REQ.**
  - `wr_req` and the data fields hold stable until `wr_ack` or `wr_err`.
  - On `wr_ack`: drop `wr_req` at the next edge and clear the retry counter.
  - After an ack, if `wr_reg_addr==8'h12 && wr_data[7]`, go to RST_WAIT. Otherwise advance.
- **Advance.** `index+1`. If the new index equals `TABLE_LEN`, go to DONE. Otherwise go to FETCH.
- **NACK.** On `wr_err`: drop `wr_req` for exactly one cycle, then re-raise it with the same fields (retry), incrementing the retry counter. If the retry counter equals `MAX_RETRY`, go to ERROR and latch `err_index` = index.
- **Ack/NACK precedence.** `wr_ack` and `wr_err` in the same cycle count as a NACK. Both inputs are ignored when `wr_req` is low.
- **RST_WAIT.** Count `RESET_WAIT_CYCLES`, then advance.
- **DONE and ERROR.** Hold. `start` restarts from IDLE behaviour, clearing `done`, `error` and `err_index`.
- **`start` while busy.** Ignored.
- **Reset.** Applies mid-operation: all state clears at the next edge. The SCCB master shares `reset` and aborts its own transfer.
- **Counter width.** Delay counters are sized `$clog2(max(POWERUP_CYCLES, RESET_WAIT_CYCLES)+1)`. The index counter is `ADDR_WIDTH+1` bits so that `TABLE_LEN==2**ADDR_WIDTH` terminates correctly.

## Timing
- **Reset values:** state IDLE; `rom_addr`=0, `wr_req`=0, `wr_dev_id`=`DEVICE_ID`, `wr_reg_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `err_index`=0.
- **`start` to first `wr_req`:** `POWERUP_CYCLES`+3 cycles (PWR_WAIT + FETCH + LOAD + 1 edge).
- **Ack to next `wr_req` (no reset write):** 3 cycles (advance edge, FETCH, LOAD).
- **Ack on the last entry:** `done` and `busy`=0 appear on the following edge.
- **Reset-register write:** next `wr_req` follows `RESET_WAIT_CYCLES`+3 cycles after the ack.
- **NACK retry:** `wr_req` is low for 1 cycle, then high.

## Configuration
- Macro `CAMERA_INIT_RETRY_EN`.
- **Defined:** the retry behaviour above, governed by `MAX_RETRY`.
- **Undefined:** the retry counter is absent; the first `wr_err` goes directly to ERROR and `MAX_RETRY` is ignored.

## Structure
- Package `camera_init_pkg` holds:
  - the state enum type;
  - `OV7725_SCCB_ID` = 8'h42;
  - `OV_REG_COM7` = 8'h12;
  - `OV_COM7_RESET_BIT` = 7.
- One sub-module, `camera_init_delay`: a loadable down-counter with `load`, `count`, `zero`. One instance is shared by PWR_WAIT and RST_WAIT.

## Test plan
- **Full table, all acks:** `POWERUP_CYCLES`=10, `RESET_WAIT_CYCLES`=20, `TABLE_LEN`=68, slave acks each write 5 cycles after `wr_req`.
  - Required: 68 writes in ROM order, the first being 0x12/0x80.
  - Required: the gap after the first ack is 23 cycles; other gaps are 3 cycles.
  - Required: `done`=1 after the 68th ack.
- **NACK then ack:** NACK entry 5 twice, then ack (retry enabled, `MAX_RETRY`=3).
  - Required: three `wr_req` assertions with identical fields, then the sequence continues.
- **Retries exhausted:** NACK entry 7 four times.
  - Required: `error`=1, `err_index`=7, `busy`=0, no further `wr_req`.
  - With `CAMERA_INIT_RETRY_EN` undefined, the first NACK gives `error`=1.
- **Reset mid-sequence:** assert `reset` while in REQ at entry 30.
  - Required: the next cycle shows `wr_req`=0 and all outputs at reset values.
  - Required: a fresh `start` begins at entry 0.
- **Start handling:**
  - `start` while busy is ignored (write count unchanged).
  - `start` after DONE clears `done` and reruns the whole table.
- **`TABLE_LEN`=0:**
  - Required: `done` after `POWERUP_CYCLES`+1 cycles and no `wr_req`.
